// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
// Provides the two-state FSM encoding and a constant clog2 helper
// used to size the bit counter.
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Number of bits needed to hold values 0..n-1 (n >= 2).
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer feeding a serial sequence detector.
// Ports: clk/reset (sync, active-high); load_valid/load_ready/load_data
// word handshake; ser_out/ser_valid serial bit stream; frame_start and
// frame_done flag the first and last bit of each frame on ser_out.
// Latency: first bit on ser_out one clk after accept; back-to-back words
// are gapless because load_ready also rises during the last bit cycle.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_done
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT_IDX = CW'(WIDTH - 2);

    state_e           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_done_q, frame_done_d;
    logic             accept;

    // Ready during the last bit so the next word follows with no gap.
    assign load_ready = (state_q == ST_IDLE) ||
                        ((state_q == ST_SHIFT) && (bit_cnt_q == LAST_IDX));
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        ser_out_d     = ser_out_q;
        ser_valid_d   = ser_valid_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;

        if (accept) begin
            state_d       = ST_SHIFT;
            bit_cnt_d     = '0;
            shreg_d       = load_data;
            ser_out_d     = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
            ser_valid_d   = 1'b1;
            frame_start_d = 1'b1;
        end else if ((state_q == ST_SHIFT) && (bit_cnt_q != LAST_IDX)) begin
            // shreg_q keeps the bit currently on ser_out at its output end,
            // so the next bit is always its neighbour.
            state_d      = ST_SHIFT;
            bit_cnt_d    = bit_cnt_q + 1'b1;
            shreg_d      = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
            ser_out_d    = MSB_FIRST ? shreg_q[WIDTH-2] : shreg_q[1];
            ser_valid_d  = 1'b1;
            frame_done_d = (bit_cnt_q == PENULT_IDX);
        end else begin
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            ser_out_d   = IDLE_LEVEL;
            ser_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            ser_out_q     <= IDLE_LEVEL;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share
// the same handshake inputs and are checked against a frame-position model.
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         load_valid;
    logic [W-1:0] load_data;

    logic rdy_m, out_m, vld_m, st_m, dn_m;
    logic rdy_l, out_l, vld_l, st_l, dn_l;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(rdy_m),
        .load_data(load_data), .ser_out(out_m), .ser_valid(vld_m),
        .frame_start(st_m), .frame_done(dn_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(rdy_l),
        .load_data(load_data), .ser_out(out_l), .ser_valid(vld_l),
        .frame_start(st_l), .frame_done(dn_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pos = index of the frame bit on ser_out, -1 when idle.
    int           pos  = -1;
    logic [W-1:0] word = '0;

    wire [9:0] obs = {rdy_m, rdy_l, out_m, out_l, vld_m, vld_l, st_m, st_l, dn_m, dn_l};

    function automatic logic [9:0] exp_vec();
        logic v, r, om, ol, s, d;
        v  = (pos >= 0);
        r  = (pos == -1) || (pos == W - 1);
        om = v ? word[W-1-pos] : 1'b0;
        ol = v ? word[pos] : 1'b0;
        s  = (pos == 0);
        d  = (pos == W - 1);
        return {r, r, om, ol, v, v, s, s, d, d};
    endfunction

    task automatic tick(input logic v, input logic [W-1:0] d, input logic r);
        load_valid = v;
        load_data  = d;
        reset      = r;
        @(posedge clk);
        #1;
        if (r) begin
            pos = -1;
        end else if (v && ((pos == -1) || (pos == W - 1))) begin
            word = d;
            pos  = 0;
        end else if ((pos >= 0) && (pos < W - 1)) begin
            pos = pos + 1;
        end else begin
            pos = -1;
        end
    endtask

    task automatic test_reset();
        tick(1'b0, '0, 1'b1);
        tick(1'b1, 8'h5A, 1'b1);
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model obs=%b exp=%b", obs, exp_vec());
        end
        checks++;
        if ({rdy_m, out_m, vld_m, st_m, dn_m} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_values obs=%b exp=10000", {rdy_m, out_m, vld_m, st_m, dn_m});
        end
    endtask

    task automatic test_single_msb();
        logic [W-1:0] pat;
        pat = 8'b1010_1101;
        tick(1'b1, pat, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL single_msb_model cycle=%0d obs=%b exp=%b", c, obs, exp_vec());
            end
            checks++;
            if (c <= 8) begin
                if ({out_m, vld_m, st_m, dn_m} !== {pat[8-c], 1'b1, (c == 1), (c == 8)}) begin
                    errors++;
                    $display("FAIL single_msb_bit cycle=%0d obs=%b exp=%b", c,
                             {out_m, vld_m, st_m, dn_m}, {pat[8-c], 1'b1, (c == 1), (c == 8)});
                end
            end else if ({out_m, vld_m} !== 2'b00) begin
                errors++;
                $display("FAIL single_msb_idle obs=%b exp=00", {out_m, vld_m});
            end
            tick(1'b0, W'($urandom), 1'b0);
        end
    endtask

    task automatic test_lsb_first();
        logic [W-1:0] expbits;
        expbits = 8'b0011_0100; // 8'h2C sent LSB-first, listed in send order
        tick(1'b1, 8'h2C, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL lsb_model cycle=%0d obs=%b exp=%b", c, obs, exp_vec());
            end
            checks++;
            if (out_l !== expbits[8-c]) begin
                errors++;
                $display("FAIL lsb_bit cycle=%0d obs=%b exp=%b", c, out_l, expbits[8-c]);
            end
            tick(1'b0, W'($urandom), 1'b0);
        end
        tick(1'b0, '0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream;
        stream = 16'b1011_0010_0100_1101;
        tick(1'b1, 8'hB2, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_model cycle=%0d obs=%b exp=%b", c, obs, exp_vec());
            end
            checks++;
            if ({out_m, vld_m, rdy_m, st_m} !==
                {stream[16-c], 1'b1, (c == 8 || c == 16), (c == 1 || c == 9)}) begin
                errors++;
                $display("FAIL b2b_stream cycle=%0d obs=%b exp=%b", c, {out_m, vld_m, rdy_m, st_m},
                         {stream[16-c], 1'b1, (c == 8 || c == 16), (c == 1 || c == 9)});
            end
            tick((c <= 8), 8'h4D, 1'b0);
        end
        checks++;
        if ({vld_m, out_m} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_idle obs=%b exp=00", {vld_m, out_m});
        end
    endtask

    task automatic test_blocking();
        logic [W-1:0] w;
        w = W'($urandom);
        tick(1'b1, w, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL block_model cycle=%0d obs=%b exp=%b", c, obs, exp_vec());
            end
            checks++;
            if (out_m !== ((c <= 8) ? w[8-c] : 1'b1)) begin
                errors++;
                $display("FAIL block_bit cycle=%0d obs=%b exp=%b", c, out_m, (c <= 8) ? w[8-c] : 1'b1);
            end
            tick((c >= 3 && c <= 8), (c >= 3) ? 8'hFF : W'($urandom), 1'b0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [W-1:0] w2;
        tick(1'b1, W'($urandom), 1'b0);
        for (int c = 1; c <= 3; c++) tick(1'b0, W'($urandom), 1'b0);
        tick(1'b0, '0, 1'b1);
        checks++;
        if ({out_m, out_l, vld_m, vld_l, dn_m, dn_l} !== 6'b0) begin
            errors++;
            $display("FAIL midreset_abort obs=%b exp=000000", {out_m, out_l, vld_m, vld_l, dn_m, dn_l});
        end
        tick(1'b0, '0, 1'b0);
        checks++;
        if ({vld_m, dn_m} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_nodone obs=%b exp=00", {vld_m, dn_m});
        end
        w2 = W'($urandom);
        tick(1'b1, w2, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if ({out_m, out_l, dn_m} !== {w2[8-c], w2[c-1], (c == 8)} || obs !== exp_vec()) begin
                errors++;
                $display("FAIL midreset_fresh cycle=%0d obs=%b exp=%b", c, obs, exp_vec());
            end
            tick(1'b0, W'($urandom), 1'b0);
        end
    endtask

    task automatic test_reset_with_valid();
        tick(1'b1, 8'hC3, 1'b0);
        tick(1'b1, 8'h3C, 1'b1);
        checks++;
        if ({rdy_m, vld_m, st_m} !== 3'b100 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_wins obs=%b exp=%b", obs, exp_vec());
        end
        tick(1'b0, '0, 1'b0);
        checks++;
        if ({rdy_m, vld_m} !== 2'b10) begin
            errors++;
            $display("FAIL reset_wins_idle obs=%b exp=10", {rdy_m, vld_m});
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            tick(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 49) == 0));
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random_model step=%0d obs=%b exp=%b", c, obs, exp_vec());
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        test_reset();
        test_single_msb();
        test_lsb_first();
        test_back_to_back();
        test_blocking();
        test_reset_midframe();
        test_reset_with_valid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
